// File: rtl/load_store_unit.sv
// Requester side of the data-memory port: takes load/store requests over valid/ready,
// drives doubleword-indexed strobes to a MEM_DEPTH x 64-bit memory and returns one response each.
module load_store_unit #(
  parameter int unsigned MEM_DEPTH    = 64,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned WRITE_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [63:0] resp_data_o,
  output logic        resp_error_o,
  output logic [63:0] address_o,
  output logic [63:0] write_data_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [63:0] read_data_i,
  output logic        busy_o
);

  localparam int unsigned MAX_CYC = (READ_LATENCY > WRITE_CYCLES) ? READ_LATENCY : WRITE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_CYCLES);
  localparam logic [60:0]      DEPTH_IDX = 61'(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [63:0]      address_q, address_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [63:0]      rdata_q, rdata_d;
  logic             accept_s;
  logic             addr_err_s;

  // Misaligned byte address or doubleword index beyond the attached memory.
  function automatic logic addr_error(input logic [63:0] addr);
    return (addr[2:0] != 3'b000) || (addr[63:3] >= DEPTH_IDX);
  endfunction

  assign accept_s   = req_valid_i && (state_q == S_IDLE);
  assign addr_err_s = addr_error(req_addr_i);

  // State, counter and datapath registers; reset wins over everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      address_q <= 64'd0;
      wdata_q   <= 64'd0;
      rdata_q   <= 64'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      address_q <= address_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next state and strobe-duration counter; counter restarts at 1 on each WRITE/READ entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          if (addr_err_s) begin
            state_d = S_RESP;
          end else if (req_write_i) begin
            state_d = S_WRITE;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = S_READ;
            cnt_d   = CNT_ONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (cnt_q == WR_LAST) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_READ: begin
        if (cnt_q == RD_LAST) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Request capture and read-data sampling; address/data hold unless a good request lands.
  always_comb begin
    err_d     = err_q;
    address_d = address_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    if (accept_s) begin
      err_d   = addr_err_s;
      rdata_d = 64'd0;
      if (!addr_err_s) begin
        address_d = {3'b000, req_addr_i[63:3]};
        if (req_write_i) begin
          wdata_d = req_wdata_i;
        end else begin
          wdata_d = wdata_q;
        end
      end else begin
        address_d = address_q;
      end
    end else if ((state_q == S_READ) && (cnt_q == RD_LAST)) begin
      rdata_d = read_data_i;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Output decode from the state register.
  always_comb begin
    req_ready_o  = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_error_o = 1'b0;
    busy_o       = 1'b1;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      S_WRITE: mem_write_o = 1'b1;
      S_READ:  mem_read_o  = 1'b1;
      S_RESP: begin
        resp_valid_o = 1'b1;
        resp_error_o = err_q;
      end
      default: busy_o = 1'b1;
    endcase
  end

  assign address_o    = address_q;
  assign write_data_o = wdata_q;
  assign resp_data_o  = rdata_q;

endmodule
